// File: rtl/firroot_ctrl.sv
// firroot_ctrl: stream and coefficient sequencer for the FIRROOT datapath.
// Double-buffered taps, gated sample feed, latency-matched result capture.
module firroot_ctrl #(
  parameter int NTAPS    = 7,
  parameter int PIPE_LAT = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  input  logic        cfg_commit,
  input  logic        start,
  input  logic        stop,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [7:0]  Data_i,
  output logic [7:0]  B0,
  output logic [7:0]  B1,
  output logic [7:0]  B2,
  output logic [7:0]  B3,
  output logic [7:0]  B4,
  output logic [7:0]  B5,
  output logic [7:0]  B6,
  input  logic [7:0]  FIRout,
  input  logic [7:0]  ROOTout,
  output logic        out_valid,
  output logic [7:0]  fir_q,
  output logic [7:0]  root_q,
  output logic [15:0] out_count,
  output logic        busy,
  output logic        cfg_err
);

  localparam int FW = $clog2(NTAPS + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(NTAPS);
  localparam logic [FW-1:0] FILL_HIT = FW'(NTAPS - 1);
  localparam logic [3:0] FLUSH_MAX = 4'(PIPE_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic v;
    logic full;
  } tag_t;

  state_t state;
  state_t state_nxt;

  tag_t [PIPE_LAT:0] tag;
  tag_t              tag_in;
  logic              tag_busy;

  logic [FW-1:0] fill;
  logic [3:0]    flush_cnt;

  logic [7:0] shadow     [NTAPS];
  logic [7:0] shadow_nxt [NTAPS];
  logic [7:0] bank       [NTAPS];

  logic bank_ok;
  logic pending;
  logic accept;
  logic go;
  logic enter_idle;
  logic addr_bad;
  logic apply;
  logic hit;

  assign busy     = (state != IDLE);
  assign in_ready = (state == RUN) && !stop;
  assign accept   = in_ready && in_valid;
  assign addr_bad = cfg_we && (cfg_addr >= 3'(NTAPS));

  assign go         = (state == IDLE) && (state_nxt == RUN);
  assign enter_idle = (state != IDLE) && (state_nxt == IDLE);

  // Commit lands at once when idle, otherwise on the way back to IDLE.
  assign apply = (state == IDLE) ? cfg_commit
               : (enter_idle && (pending || cfg_commit));

  assign hit = tag[PIPE_LAT].v && tag[PIPE_LAT].full;

  assign B0 = bank[0];
  assign B1 = bank[1];
  assign B2 = bank[2];
  assign B3 = bank[3];
  assign B4 = bank[4];
  assign B5 = bank[5];
  assign B6 = bank[6];

  // New tag: marks a real sample and whether the tap window is full.
  always_comb begin
    tag_in      = '0;
    tag_in.v    = accept;
    tag_in.full = accept && (fill >= FILL_HIT);
  end

  // Any real sample still travelling through the datapath.
  always_comb begin
    tag_busy = 1'b0;
    for (int i = 0; i <= PIPE_LAT; i++) begin
      tag_busy = tag_busy | tag[i].v;
    end
  end

  // Sequencer next state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start && !stop && bank_ok) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_cnt == FLUSH_MAX && !tag_busy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Drain timer: edges spent in FLUSH.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      flush_cnt <= '0;
    end else if (state != FLUSH) begin
      flush_cnt <= '0;
    end else if (flush_cnt != FLUSH_MAX) begin
      flush_cnt <= flush_cnt + 4'd1;
    end
  end

  // Tap window fill level since start.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fill <= '0;
    end else if (go) begin
      fill <= '0;
    end else if (accept && fill != FILL_MAX) begin
      fill <= fill + FW'(1);
    end
  end

  // Sample feed; bubbles push zeros since the FIR never stalls.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Data_i <= '0;
      tag    <= '0;
    end else begin
      Data_i <= accept ? in_data : 8'd0;
      tag    <= {tag[PIPE_LAT-1:0], tag_in};
    end
  end

  // Result capture aligned to the datapath latency.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid <= 1'b0;
      fir_q     <= '0;
      root_q    <= '0;
    end else begin
      out_valid <= hit;
      if (hit) begin
        fir_q  <= FIRout;
        root_q <= ROOTout;
      end
    end
  end

  // Result counter, restarted by each start.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_count <= '0;
    end else if (go) begin
      out_count <= '0;
    end else if (hit) begin
      out_count <= out_count + 16'd1;
    end
  end

  // Shadow bank with the same-cycle write folded in.
  always_comb begin
    for (int i = 0; i < NTAPS; i++) begin
      shadow_nxt[i] = shadow[i];
      if (cfg_we && cfg_addr == 3'(i)) begin
        shadow_nxt[i] = cfg_data;
      end
    end
  end

  // Shadow register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NTAPS; i++) begin
        shadow[i] <= shadow_nxt[i];
      end
    end
  end

  // Live bank and the flag that a bank has ever been committed.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        bank[i] <= '0;
      end
      bank_ok <= 1'b0;
    end else if (apply) begin
      for (int i = 0; i < NTAPS; i++) begin
        bank[i] <= shadow_nxt[i];
      end
      bank_ok <= 1'b1;
    end
  end

  // Commit requested while streaming waits here.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pending <= 1'b0;
    end else if (apply) begin
      pending <= 1'b0;
    end else if (cfg_commit && state != IDLE) begin
      pending <= 1'b1;
    end
  end

  // Error pulse: bad address or start with no usable bank.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= addr_bad
              || (state == IDLE && start && !stop && !bank_ok);
    end
  end

endmodule

// File: tb/tb_firroot_ctrl.sv
// tb_firroot_ctrl: scoreboard bench for firroot_ctrl.
// A stub datapath tags each sample so captured results identify their source.
module tb_firroot_ctrl;

  localparam int PL = 2;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        cfg_commit;
  logic        start;
  logic        stop;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [7:0]  Data_i;
  logic [7:0]  B0, B1, B2, B3, B4, B5, B6;
  logic [7:0]  FIRout;
  logic [7:0]  ROOTout;
  logic        out_valid;
  logic [7:0]  fir_q;
  logic [7:0]  root_q;
  logic [15:0] out_count;
  logic        busy;
  logic        cfg_err;

  typedef struct packed {
    logic [7:0] fir;
    logic [7:0] root;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_seen  = 0;
  int   cyc     = 0;
  int   acc     = 0;

  logic [7:0] p1 = 8'd0;
  logic [7:0] p2 = 8'd0;

  firroot_ctrl #(.NTAPS(7), .PIPE_LAT(PL)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .start(start), .stop(stop),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .Data_i(Data_i),
    .B0(B0), .B1(B1), .B2(B2), .B3(B3),
    .B4(B4), .B5(B5), .B6(B6),
    .FIRout(FIRout), .ROOTout(ROOTout),
    .out_valid(out_valid), .fir_q(fir_q),
    .root_q(root_q), .out_count(out_count),
    .busy(busy), .cfg_err(cfg_err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [7:0] fir_of(input logic [7:0] d);
    return d ^ 8'hA5;
  endfunction

  function automatic logic [7:0] root_of(input logic [7:0] d);
    return {d[3:0], d[7:4]} + 8'd1;
  endfunction

  // Two-stage datapath stand-in.
  always @(posedge Clk) begin
    p1 <= Data_i;
    p2 <= p1;
  end
  assign FIRout  = fir_of(p2);
  assign ROOTout = root_of(p2);

  function automatic logic [55:0] bankv();
    return {B0, B1, B2, B3, B4, B5, B6};
  endfunction

  task automatic mon();
    exp_t e;
    if (out_valid === 1'b1) begin
      n_seen++;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL out_valid_unexpected: cyc=%0d fir_q=%h, required no result",
                 cyc, fir_q);
      end else begin
        e = sb.pop_front();
        if (fir_q !== e.fir || root_q !== e.root || cyc != e.due) begin
          n_fail++;
          $display("FAIL result: fir_q=%h root_q=%h cyc=%0d, required %h %h cyc=%0d",
                   fir_q, root_q, cyc, e.fir, e.root, e.due);
        end
      end
    end else if (sb.size() != 0 && cyc > sb[0].due) begin
      n_tests++;
      n_fail++;
      e = sb.pop_front();
      $display("FAIL result_missing: cyc=%0d no out_valid, required fir_q=%h at cyc=%0d",
               cyc, e.fir, e.due);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    mon();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    acc = 0;
  endtask

  task automatic feed(input logic v, input logic [7:0] d);
    exp_t e;
    in_valid = v;
    in_data  = d;
    if (v) begin
      acc++;
      if (acc >= 7) begin
        e.fir  = fir_of(d);
        e.root = root_of(d);
        e.due  = cyc + PL + 2;
        sb.push_back(e);
      end
    end
    tick();
    in_valid = 1'b0;
    in_data  = 8'd0;
  endtask

  task automatic do_stop(output int edges);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    edges = 0;
    while (busy === 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if ({Data_i, bankv(), fir_q, root_q, out_count} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_values_held: got %h, required 0",
               {Data_i, bankv(), fir_q, root_q, out_count});
    end
    @(posedge Clk);
    #3 Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    n_tests++;
    if ({Data_i, bankv(), fir_q, root_q, out_count} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_values: got %h, required 0",
               {Data_i, bankv(), fir_q, root_q, out_count});
    end
    n_tests++;
    if ({in_ready, out_valid, busy, cfg_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 0000",
               {in_ready, out_valid, busy, cfg_err});
    end
  endtask

  task automatic test_no_bank();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if ({cfg_err, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL no_bank_err: cfg_err,busy=%b, required 10", {cfg_err, busy});
    end
    tick();
    n_tests++;
    if ({cfg_err, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL no_bank_pulse: cfg_err,busy=%b, required 00", {cfg_err, busy});
    end
  endtask

  task automatic test_config();
    for (int i = 0; i < 7; i++) begin
      cfg_we   = 1'b1;
      cfg_addr = 3'(i);
      cfg_data = 8'(i + 1);
      tick();
    end
    cfg_we = 1'b0;
    n_tests++;
    if (bankv() !== 56'd0) begin
      n_fail++;
      $display("FAIL bank_before_commit: got %h, required 0", bankv());
    end
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    n_tests++;
    if (bankv() !== 56'h01020304050607) begin
      n_fail++;
      $display("FAIL bank_commit: got %h, required 01020304050607", bankv());
    end
    cfg_we   = 1'b1;
    cfg_addr = 3'd7;
    cfg_data = 8'hFF;
    tick();
    cfg_we = 1'b0;
    n_tests++;
    if (cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_addr_err: cfg_err=%b, required 1", cfg_err);
    end
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    n_tests++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_addr_pulse: cfg_err=%b, required 0", cfg_err);
    end
    n_tests++;
    if (bankv() !== 56'h01020304050607) begin
      n_fail++;
      $display("FAIL bad_addr_bank: got %h, required 01020304050607", bankv());
    end
  endtask

  task automatic test_start_stop();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    n_tests++;
    if ({busy, in_ready, cfg_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL start_stop_idle: busy,in_ready,cfg_err=%b, required 000",
               {busy, in_ready, cfg_err});
    end
  endtask

  task automatic test_stream();
    int seen0;
    int edges;
    logic [7:0] d;
    do_start();
    n_tests++;
    if ({busy, in_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL run_entry: busy,in_ready=%b, required 11", {busy, in_ready});
    end
    seen0 = n_seen;
    for (int i = 0; i < 21; i++) begin
      d = 8'(i * 13 + 7);
      feed(1'b1, d);
      n_tests++;
      if (Data_i !== d) begin
        n_fail++;
        $display("FAIL stream_data_i: got %h, required %h", Data_i, d);
      end
    end
    do_stop(edges);
    n_tests++;
    if (edges != PL + 1) begin
      n_fail++;
      $display("FAIL stream_drain: busy fell after %0d edges, required %0d",
               edges, PL + 1);
    end
    n_tests++;
    if (out_count !== 16'd15 || n_seen - seen0 != 15) begin
      n_fail++;
      $display("FAIL stream_count: out_count=%0d seen=%0d, required 15",
               out_count, n_seen - seen0);
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL stream_left: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_bubbles();
    int seen0;
    int edges;
    logic v;
    logic [7:0] d;
    do_start();
    n_tests++;
    if (out_count !== 16'd0) begin
      n_fail++;
      $display("FAIL count_clear: out_count=%0d, required 0", out_count);
    end
    seen0 = n_seen;
    for (int i = 0; i < 20; i++) begin
      v = (i % 2 == 0);
      d = 8'(i * 29 + 3);
      feed(v, d);
      n_tests++;
      if (Data_i !== (v ? d : 8'd0)) begin
        n_fail++;
        $display("FAIL bubble_data_i: got %h, required %h", Data_i, v ? d : 8'd0);
      end
    end
    do_stop(edges);
    n_tests++;
    if (out_count !== 16'd4 || n_seen - seen0 != 4) begin
      n_fail++;
      $display("FAIL bubble_count: out_count=%0d seen=%0d, required 4",
               out_count, n_seen - seen0);
    end
  endtask

  task automatic test_deferred();
    do_start();
    for (int i = 0; i < 7; i++) begin
      cfg_we   = 1'b1;
      cfg_addr = 3'(i);
      cfg_data = 8'(8'h10 + i);
      tick();
    end
    cfg_we = 1'b0;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    n_tests++;
    if (bankv() !== 56'h01020304050607) begin
      n_fail++;
      $display("FAIL defer_run: got %h, required 01020304050607", bankv());
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int j = 1; j <= PL + 1; j++) begin
      tick();
      n_tests++;
      if (j <= PL) begin
        if (bankv() !== 56'h01020304050607 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL defer_flush: edge %0d bank=%h busy=%b, required old bank busy=1",
                   j, bankv(), busy);
        end
      end else begin
        if (bankv() !== 56'h10111213141516 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL defer_apply: bank=%h busy=%b, required 10111213141516 busy=0",
                   bankv(), busy);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    for (int i = 0; i < 8; i++) begin
      feed(1'b1, 8'(i * 7 + 40));
    end
    sb.delete();
    in_valid = 1'b1;
    in_data  = 8'h77;
    #2 Rst_n = 1'b0;
    #1;
    n_tests++;
    if ({Data_i, bankv(), fir_q, root_q, out_count} !== 96'd0) begin
      n_fail++;
      $display("FAIL mid_reset_values: got %h, required 0",
               {Data_i, bankv(), fir_q, root_q, out_count});
    end
    n_tests++;
    if ({in_ready, out_valid, busy, cfg_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_flags: got %b, required 0000",
               {in_ready, out_valid, busy, cfg_err});
    end
    tick();
    #2 Rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    in_valid = 1'b0;
    n_tests++;
    if (out_count !== 16'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_after: out_count=%0d busy=%b, required 0 0",
               out_count, busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if ({cfg_err, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_reset_bank: cfg_err,busy=%b, required 10", {cfg_err, busy});
    end
  endtask

  initial begin
    Rst_n      = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = 3'd0;
    cfg_data   = 8'd0;
    cfg_commit = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'd0;
    test_reset();
    test_no_bank();
    test_config();
    test_start_stop();
    test_stream();
    test_bubbles();
    test_deferred();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
